alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_issuer.sv | 138 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding, command layout and reference ALU function
// for the ALU command issuer.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_XOR = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
  localparam int         CMD_W        = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  // 8-bit result; addition wraps and the carry is discarded.
  function automatic logic [7:0] alu_ref(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full flag comes from the registered count, so a
// push while full is dropped even if a pop happens in the same cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues host ALU commands and issues them one at a time, returning each result
// (or 8'hFF on timeout). Define ALU_ISSUER_CHECK_EN to enable the result checker.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_a,
  input  logic [7:0] i_cmd_b,
  input  logic [1:0] i_cmd_op,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic [1:0] o_operand,
  output logic       o_valid,
  input  logic [7:0] i_result,
  input  logic       i_res_valid,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  input  logic       i_rsp_ready,
  output logic       o_timeout,
  output logic       o_mismatch
);
  // Counter value during the last WAIT cycle before giving up.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  cmd_t       push_cmd, head_cmd;
  logic       fifo_full, fifo_empty;
  logic       pop, capture, expire;
  logic [7:0] a_q, b_q, rsp_q;
  logic [1:0] op_q;
  logic       timeout_q;

  assign push_cmd = '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b};

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_wdata (push_cmd),
    .i_pop   (pop),
    .o_rdata (head_cmd),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_cmd_ready = !fifo_full;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;
  assign capture     = (state_q == ST_WAIT) && i_res_valid;
  assign expire      = (state_q == ST_WAIT) && !i_res_valid && (wait_cnt_q == TMO_LAST);
  assign wait_cnt_d  = (state_q == ST_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (capture || expire) state_d = ST_RESP;
      ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_valid     = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state_q)
      ST_ISSUE: o_valid     = 1'b1;
      ST_RESP:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop) begin
        a_q  <= head_cmd.a;
        b_q  <= head_cmd.b;
        op_q <= head_cmd.op;
      end
      if (capture) begin
        rsp_q <= i_result;
      end else if (expire) begin
        rsp_q     <= TIMEOUT_FILL;
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_a        = a_q;
  assign o_b        = b_q;
  assign o_operand  = op_q;
  assign o_rsp_data = rsp_q;
  assign o_timeout  = timeout_q;

`ifdef ALU_ISSUER_CHECK_EN
  logic mismatch_q;

  // Only real captures are compared; timeout fills never are.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mismatch_q <= 1'b0;
    end else if (capture && (i_result != alu_ref(op_q, a_q, b_q))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign o_mismatch = mismatch_q;
`else
  assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with a behavioural ALU
// responder and a queue-based reference model of the expected responses.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;
`ifdef ALU_ISSUER_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  logic       i_clk, i_rst, i_cmd_valid, o_cmd_ready;
  logic [7:0] i_cmd_a, i_cmd_b, o_a, o_b, i_result, o_rsp_data;
  logic [1:0] i_cmd_op, o_operand;
  logic       o_valid, i_res_valid, o_rsp_valid, i_rsp_ready, o_timeout, o_mismatch;

  int         n_cmp, n_err;
  int         alu_mode = 0;   // 0 correct, 1 silent, 2 returns 8'h00, 3 spurious strobes
  bit         alu_pend;
  logic [7:0] alu_val;

  alu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op),
    .o_a(o_a), .o_b(o_b), .o_operand(o_operand), .o_valid(o_valid),
    .i_result(i_result), .i_res_valid(i_res_valid),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .i_rsp_ready(i_rsp_ready),
    .o_timeout(o_timeout), .o_mismatch(o_mismatch)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 256;
      1:       r = a ^ b;
      2:       r = a | b;
      default: r = a & b;
    endcase
    return r[7:0];
  endfunction

  // ALU model: answers in the first WAIT cycle after seeing o_valid.
  initial begin
    i_res_valid = 1'b0;
    i_result    = 8'h00;
    alu_pend    = 1'b0;
    alu_val     = 8'h00;
    forever begin
      @(negedge i_clk);
      i_res_valid = 1'b0;
      if (alu_mode == 3) begin
        i_res_valid = 1'b1;
        i_result    = 8'h5A;
      end else if (alu_pend) begin
        i_res_valid = 1'b1;
        i_result    = alu_val;
      end
      alu_pend = 1'b0;
      if (o_valid && (alu_mode == 0 || alu_mode == 2)) begin
        alu_pend = 1'b1;
        alu_val  = (alu_mode == 0) ? ref_alu(o_a, o_b, o_operand) : 8'h00;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic accept();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  // lat counts rising edges after the push edge until o_rsp_valid (or budget).
  task automatic wait_rsp(input int budget, output int lat, output int nvld,
                          output logic [7:0] va, output logic [7:0] vb, output logic [1:0] vop);
    lat = 0; nvld = 0; va = 8'h00; vb = 8'h00; vop = 2'd0;
    while (!o_rsp_valid && lat < budget) begin
      if (o_valid) begin nvld++; va = o_a; vb = o_b; vop = o_operand; end
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_valid, o_rsp_valid, o_a, o_b, o_operand, o_rsp_data, o_timeout, o_mismatch} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b rv=%b a=%h b=%h op=%h d=%h to=%b mm=%b required all zero",
               o_valid, o_rsp_valid, o_a, o_b, o_operand, o_rsp_data, o_timeout, o_mismatch);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", o_cmd_ready); end
  endtask

  task automatic test_basic();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    push_one(8'h0F, 8'h01, 2'd0);
    wait_rsp(20, lat, nv, va, vb, vop);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d required 3", lat); end
    n_cmp++; if (nv != 1) begin n_err++; $display("FAIL basic_issue_pulses: got %0d required 1", nv); end
    n_cmp++; if ({va, vb, vop} !== {8'h0F, 8'h01, 2'd0}) begin
      n_err++; $display("FAIL basic_operands: got %h %h %h required 0f 01 0", va, vb, vop); end
    n_cmp++; if (o_rsp_data !== 8'h10) begin n_err++; $display("FAIL basic_data: got %h required 10", o_rsp_data); end
    n_cmp++; if (o_a !== 8'h0F) begin n_err++; $display("FAIL basic_hold_a: got %h required 0f", o_a); end
    accept();
    n_cmp++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_rsp_drop: got %b required 0", o_rsp_valid); end
  endtask

  task automatic test_wrap();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    push_one(8'hFF, 8'h02, 2'd0);
    wait_rsp(20, lat, nv, va, vb, vop);
    n_cmp++; if (o_rsp_data !== 8'h01) begin n_err++; $display("FAIL wrap_data: got %h required 01", o_rsp_data); end
    n_cmp++; if (o_mismatch !== 1'b0) begin n_err++; $display("FAIL wrap_mismatch: got %b required 0", o_mismatch); end
    accept();
  endtask

  task automatic test_fifo_full();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    logic [7:0] q[$]; logic [7:0] a, b, e; logic [1:0] op;
    push_one(8'h21, 8'h12, 2'd2);
    wait_rsp(20, lat, nv, va, vb, vop);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (o_cmd_ready !== (k < DEPTH)) begin
        n_err++; $display("FAIL full_ready_%0d: got %b required %b", k, o_cmd_ready, (k < DEPTH)); end
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
      if (k < DEPTH) q.push_back(ref_alu(a, b, op));
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0;
    n_cmp++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_after: got %b required 0", o_cmd_ready); end
    n_cmp++; if (o_rsp_data !== 8'h33) begin n_err++; $display("FAIL full_first_data: got %h required 33", o_rsp_data); end
    accept();
    for (int k = 0; k < DEPTH; k++) begin
      wait_rsp(20, lat, nv, va, vb, vop);
      e = q.pop_front();
      n_cmp++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== e) begin
        n_err++; $display("FAIL full_rsp_%0d: got valid=%b data=%h required valid=1 data=%h", k, o_rsp_valid, o_rsp_data, e); end
      accept();
    end
    wait_rsp(10, lat, nv, va, vb, vop);
    n_cmp++; if (lat != 10 || nv != 0) begin
      n_err++; $display("FAIL full_dropped_fifth: got lat=%0d issues=%0d required lat=10 issues=0", lat, nv); end
  endtask

  task automatic test_random();
    logic [7:0] q[$]; logic [7:0] a, b, e; logic [1:0] op;
    for (int cyc = 0; cyc < 700; cyc++) begin
      i_rsp_ready = ($urandom_range(0, 2) != 0);
      if (o_rsp_valid && i_rsp_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected: got response %h required none", o_rsp_data);
        end else begin
          e = q.pop_front();
          if (o_rsp_data !== e) begin n_err++; $display("FAIL rand_data: got %h required %h", o_rsp_data, e); end
        end
      end
      i_cmd_valid = 1'b0;
      if (cyc < 550 && o_cmd_ready && $urandom_range(0, 1) == 1) begin
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        i_cmd_valid = 1'b1; i_cmd_a = a; i_cmd_b = b; i_cmd_op = op;
        q.push_back(ref_alu(a, b, op));
      end
      @(negedge i_clk);
    end
    i_rsp_ready = 1'b0; i_cmd_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d outstanding required 0", q.size()); end
    n_cmp++; if (o_mismatch !== 1'b0) begin n_err++; $display("FAIL rand_mismatch: got %b required 0", o_mismatch); end
  endtask

  task automatic test_timeout();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    alu_mode = 1;
    push_one(8'h55, 8'h0A, 2'd1);
    wait_rsp(60, lat, nv, va, vb, vop);
    n_cmp++; if (lat != 2 + TMO) begin n_err++; $display("FAIL tmo_latency: got %0d required %0d", lat, 2 + TMO); end
    n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b required 1", o_timeout); end
    n_cmp++; if (o_rsp_data !== 8'hFF) begin n_err++; $display("FAIL tmo_data: got %h required ff", o_rsp_data); end
    alu_mode = 3;
    repeat (3) @(negedge i_clk);
    alu_mode = 0;
    @(negedge i_clk);
    n_cmp++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 8'hFF) begin
      n_err++; $display("FAIL tmo_spurious: got valid=%b data=%h required valid=1 data=ff", o_rsp_valid, o_rsp_data); end
    accept();
    push_one(8'h30, 8'h0C, 2'd2);
    wait_rsp(20, lat, nv, va, vb, vop);
    n_cmp++; if (lat != 3 || o_rsp_data !== 8'h3C) begin
      n_err++; $display("FAIL tmo_next_cmd: got lat=%0d data=%h required lat=3 data=3c", lat, o_rsp_data); end
    n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b required 1", o_timeout); end
    accept();
  endtask

  task automatic test_mismatch();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    alu_mode = 2;
    push_one(8'hF0, 8'h3C, 2'd3);
    wait_rsp(20, lat, nv, va, vb, vop);
    n_cmp++; if (o_rsp_data !== 8'h00) begin n_err++; $display("FAIL mm_data: got %h required 00", o_rsp_data); end
    n_cmp++; if (o_mismatch !== EXP_MM) begin n_err++; $display("FAIL mm_flag: got %b required %b", o_mismatch, EXP_MM); end
    accept();
    alu_mode = 0;
  endtask

  task automatic test_reset_midop();
    int lat, nv; logic [7:0] va, vb; logic [1:0] vop;
    alu_mode = 1;
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_cmd_a = 8'(k + 1); i_cmd_b = 8'h40; i_cmd_op = 2'd0;
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_valid, o_rsp_valid, o_a, o_b, o_operand, o_rsp_data, o_timeout, o_mismatch} !== 30'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v=%b rv=%b a=%h b=%h op=%h d=%h to=%b mm=%b required all zero",
               o_valid, o_rsp_valid, o_a, o_b, o_operand, o_rsp_data, o_timeout, o_mismatch);
    end
    i_rst = 1'b1;
    alu_mode = 0;
    @(negedge i_clk);
    n_cmp++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b required 1", o_cmd_ready); end
    wait_rsp(30, lat, nv, va, vb, vop);
    n_cmp++; if (lat != 30 || nv != 0) begin
      n_err++; $display("FAIL midreset_no_activity: got lat=%0d issues=%0d required lat=30 issues=0", lat, nv); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_a = 8'h00; i_cmd_b = 8'h00; i_cmd_op = 2'd0;
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_wrap();
    test_fifo_full();
    test_random();
    test_timeout();
    test_mismatch();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
